// File: rtl/draw_pkg.sv
// Shared defaults and FSM state encoding for the draw sequencer.
package draw_pkg;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;
  localparam int DEF_COL_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_SCAN       = 3'd3,
    ST_SERVE      = 3'd4
  } state_e;

endpackage

// File: rtl/screen_sweep.sv
// Raster counter: x runs 0..SCREEN_W-1 inside y 0..SCREEN_H-1, advancing
// one position per enabled cycle and wrapping to (0,0) after the last pixel.
module screen_sweep
  import draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_wrap;

  // Next raster position; y only moves when x wraps.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x_wrap = (x_q == X_MAX);
    if (en_i) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/draw_sequencer.sv
// Frame-buffer write sequencer: clears the screen, then on every frame tick
// walks the sprite channels in index order, granting each requesting channel
// exclusive use of the registered write port until it signals done.
//
// Channel handshake: ch_grant[i] is high while channel i owns the port; a
// granted channel's ch_plot marks a valid pixel (written one cycle later) and
// ch_done marks its last cycle of ownership (that cycle's pixel is still
// written). Ungranted channels' ch_plot/ch_done are ignored.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int X_W          = DEF_X_W,
  parameter int Y_W          = DEF_Y_W,
  parameter int COL_W        = DEF_COL_W,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int CLEAR_COLOUR = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clear_req,
  input  logic                    frame_tick,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*X_W-1:0]   ch_x,
  input  logic [NUM_CH*Y_W-1:0]   ch_y,
  input  logic [NUM_CH*COL_W-1:0] ch_colour,
  input  logic [NUM_CH-1:0]       ch_plot,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_grant,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [COL_W-1:0]        colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    overrun,
  output logic [2:0]              dbg_state
);

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [COL_W-1:0] CLR_COL  = COL_W'(CLEAR_COLOUR);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             overrun_q, overrun_d;

  logic             sweep_en;
  logic             sweep_last;
  logic [X_W-1:0]   sweep_x;
  logic [Y_W-1:0]   sweep_y;

  logic             sel_req, sel_plot, sel_done;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [COL_W-1:0] sel_col;

  screen_sweep #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .clk    (clk),
    .reset  (reset),
    .en_i   (sweep_en),
    .x_o    (sweep_x),
    .y_o    (sweep_y),
    .last_o (sweep_last)
  );

  // Select the channel at the current scan index.
  always_comb begin
    sel_req  = 1'b0;
    sel_plot = 1'b0;
    sel_done = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_req  = ch_req[i];
        sel_plot = ch_plot[i];
        sel_done = ch_done[i];
        sel_x    = ch_x[i*X_W +: X_W];
        sel_y    = ch_y[i*Y_W +: Y_W];
        sel_col  = ch_colour[i*COL_W +: COL_W];
      end
    end
  end

  // Next-state and write-port logic; plot defaults low, coordinates hold.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    overrun_d = overrun_q;
    sweep_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        sweep_en = 1'b1;
        plot_d   = 1'b1;
        x_d      = sweep_x;
        y_d      = sweep_y;
        colour_d = CLR_COL;
        if (frame_tick) overrun_d = 1'b1;
        if (sweep_last) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (frame_tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (frame_tick) overrun_d = 1'b1;
        if (sel_req) begin
          state_d = ST_SERVE;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_WAIT_FRAME;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_SERVE: begin
        if (frame_tick) overrun_d = 1'b1;
        plot_d = sel_plot;
        if (sel_plot) begin
          x_d      = sel_x;
          y_d      = sel_y;
          colour_d = sel_col;
        end
        if (sel_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_WAIT_FRAME;
            idx_d   = '0;
          end else begin
            state_d = ST_SCAN;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant is one-hot on the scan index, and only while serving.
  always_comb begin
    ch_grant = '0;
    if (state_q == ST_SERVE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_grant[i] = (idx_q == IDX_W'(i));
      end
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      overrun_q <= overrun_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_WAIT_FRAME);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer on a reduced 20x12 screen so that full
// clears stay short; channel count and field widths use their defaults.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int NUM_CH = 4;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int COL_W  = 3;
  localparam int SW     = 20;
  localparam int SH     = 12;
  localparam int PIX_W  = Y_W + X_W + COL_W;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic                    clear_req;
  logic                    frame_tick;
  logic [NUM_CH-1:0]       ch_req;
  logic [NUM_CH*X_W-1:0]   ch_x;
  logic [NUM_CH*Y_W-1:0]   ch_y;
  logic [NUM_CH*COL_W-1:0] ch_colour;
  logic [NUM_CH-1:0]       ch_plot;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH-1:0]       ch_grant;
  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic [COL_W-1:0]        colour;
  logic                    plot;
  logic                    busy;
  logic                    overrun;
  logic [2:0]              dbg_state;

  int checks;
  int errors;
  logic [PIX_W-1:0] exp_q[$];

  draw_sequencer #(
    .NUM_CH       (NUM_CH),
    .X_W          (X_W),
    .Y_W          (Y_W),
    .COL_W        (COL_W),
    .SCREEN_W     (SW),
    .SCREEN_H     (SH),
    .CLEAR_COLOUR (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clear_req  (clear_req),
    .frame_tick (frame_tick),
    .ch_req     (ch_req),
    .ch_x       (ch_x),
    .ch_y       (ch_y),
    .ch_colour  (ch_colour),
    .ch_plot    (ch_plot),
    .ch_done    (ch_done),
    .ch_grant   (ch_grant),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int cx, input int cy, input int cc);
    ch_x[i*X_W +: X_W]         = X_W'(cx);
    ch_y[i*Y_W +: Y_W]         = Y_W'(cy);
    ch_colour[i*COL_W +: COL_W] = COL_W'(cc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %0b want 0", plot); end
    checks++; if (x !== '0 || y !== '0 || colour !== '0) begin errors++; $display("FAIL reset_xyc got %0d,%0d,%0d want 0,0,0", x, y, colour); end
    checks++; if (ch_grant !== '0) begin errors++; $display("FAIL reset_grant got %b want 0000", ch_grant); end
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_busy_ovr got %0b%0b want 00", busy, overrun); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    // IDLE holds without start; clear_req and frame_tick are ignored there.
    clear_req  = 1'b1;
    frame_tick = 1'b1;
    tick();
    clear_req  = 1'b0;
    frame_tick = 1'b0;
    repeat (2) tick();
    checks++; if (dbg_state !== ST_IDLE || plot !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL idle_hold got state %0d plot %0b ovr %0b want 0 0 0", dbg_state, plot, overrun);
    end
  endtask

  task automatic test_clear();
    int  seen;
    bit  done;
    logic [PIX_W-1:0] e;
    exp_q.delete();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        exp_q.push_back({Y_W'(yy), X_W'(xx), COL_W'(0)});
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (dbg_state !== ST_CLEAR || busy !== 1'b1 || plot !== 1'b0) begin
      errors++; $display("FAIL clear_entry got state %0d busy %0b plot %0b want %0d 1 0", dbg_state, busy, plot, ST_CLEAR);
    end
    seen = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      if (plot === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL clear_extra_pixel got %0d,%0d want none", x, y);
        end else begin
          e = exp_q.pop_front();
          if ({y, x, colour} !== e) begin
            errors++; $display("FAIL clear_pixel got %0d,%0d,%0d want %0d,%0d,%0d", x, y, colour, e[PIX_W-1 -: Y_W], e[COL_W +: X_W], e[COL_W-1:0]);
          end
        end
        seen++;
      end else if (seen > 0) begin
        done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL clear_timeout got %0d plots want end of sweep", seen); end
    checks++; if (seen != SW*SH) begin errors++; $display("FAIL clear_count got %0d want %0d", seen, SW*SH); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clear_missing got %0d left want 0", exp_q.size()); end
    checks++; if (busy !== 1'b0 || dbg_state !== ST_WAIT_FRAME) begin
      errors++; $display("FAIL clear_exit got busy %0b state %0d want 0 %0d", busy, dbg_state, ST_WAIT_FRAME);
    end
    checks++; if (x !== X_W'(SW-1) || y !== Y_W'(SH-1)) begin
      errors++; $display("FAIL clear_hold got %0d,%0d want %0d,%0d", x, y, SW-1, SH-1);
    end
  endtask

  task automatic test_scan_serve();
    ch_req = 4'b1010;
    set_ch(0, 1, 1, 1);
    set_ch(1, 5, 7, 3);
    set_ch(3, 300, 200, 6);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++; if (dbg_state !== ST_SCAN || ch_grant !== 4'b0000 || overrun !== 1'b0) begin
      errors++; $display("FAIL scan_entry got state %0d grant %b ovr %0b want %0d 0000 0", dbg_state, ch_grant, overrun, ST_SCAN);
    end
    tick();
    checks++; if (ch_grant !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL skip_ch0 got grant %b busy %0b want 0000 1", ch_grant, busy);
    end
    tick();
    checks++; if (ch_grant !== 4'b0010) begin errors++; $display("FAIL grant_ch1 got %b want 0010", ch_grant); end
    // Channel 0 raises plot/done too; it is not granted and must be ignored.
    ch_plot = 4'b0011;
    ch_done = 4'b0001;
    tick();
    checks++; if (plot !== 1'b1 || x !== 9'd5 || y !== 8'd7 || colour !== 3'd3) begin
      errors++; $display("FAIL serve_pixel got %0b %0d,%0d,%0d want 1 5,7,3", plot, x, y, colour);
    end
    checks++; if (ch_grant !== 4'b0010) begin errors++; $display("FAIL serve_keep got %b want 0010", ch_grant); end
    // Late frame tick while serving: flagged, sequence continues.
    ch_plot    = 4'b0000;
    ch_done    = 4'b0000;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++; if (plot !== 1'b0 || x !== 9'd5 || y !== 8'd7 || colour !== 3'd3) begin
      errors++; $display("FAIL serve_idle got %0b %0d,%0d,%0d want 0 5,7,3", plot, x, y, colour);
    end
    checks++; if (overrun !== 1'b1 || ch_grant !== 4'b0010) begin
      errors++; $display("FAIL overrun_set got ovr %0b grant %b want 1 0010", overrun, ch_grant);
    end
    set_ch(1, 9, 4, 2);
    ch_plot = 4'b0010;
    ch_done = 4'b0010;
    tick();
    ch_plot = 4'b0000;
    ch_done = 4'b0000;
    checks++; if (plot !== 1'b1 || x !== 9'd9 || y !== 8'd4 || colour !== 3'd2 || ch_grant !== 4'b0000) begin
      errors++; $display("FAIL done_pixel got %0b %0d,%0d,%0d grant %b want 1 9,4,2 0000", plot, x, y, colour, ch_grant);
    end
    tick();
    checks++; if (ch_grant !== 4'b0000 || plot !== 1'b0 || dbg_state !== ST_SCAN) begin
      errors++; $display("FAIL skip_ch2 got grant %b plot %0b state %0d want 0000 0 %0d", ch_grant, plot, dbg_state, ST_SCAN);
    end
    tick();
    checks++; if (ch_grant !== 4'b1000) begin errors++; $display("FAIL grant_ch3 got %b want 1000", ch_grant); end
    ch_plot = 4'b1000;
    ch_done = 4'b1000;
    tick();
    ch_plot = 4'b0000;
    ch_done = 4'b0000;
    ch_req  = 4'b0000;
    checks++; if (plot !== 1'b1 || x !== 9'd300 || y !== 8'd200 || colour !== 3'd6) begin
      errors++; $display("FAIL ch3_pixel got %0b %0d,%0d,%0d want 1 300,200,6", plot, x, y, colour);
    end
    checks++; if (ch_grant !== 4'b0000 || busy !== 1'b0 || dbg_state !== ST_WAIT_FRAME) begin
      errors++; $display("FAIL frame_end got grant %b busy %0b state %0d want 0000 0 %0d", ch_grant, busy, dbg_state, ST_WAIT_FRAME);
    end
    tick();
    checks++; if (plot !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL wait_quiet got plot %0b ovr %0b want 0 1", plot, overrun);
    end
  endtask

  task automatic test_empty_frame();
    int busy_cycles;
    ch_req = 4'b0000;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 20 && busy === 1'b1; c++) begin
      busy_cycles++;
      tick();
    end
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL empty_scan got %0d busy cycles want 4", busy_cycles); end
    checks++; if (dbg_state !== ST_WAIT_FRAME || ch_grant !== 4'b0000) begin
      errors++; $display("FAIL empty_end got state %0d grant %b want %0d 0000", dbg_state, ch_grant, ST_WAIT_FRAME);
    end
  endtask

  task automatic test_clear_priority_abort();
    bit found;
    int plots;
    clear_req  = 1'b1;
    frame_tick = 1'b1;
    tick();
    clear_req  = 1'b0;
    frame_tick = 1'b0;
    checks++; if (dbg_state !== ST_CLEAR || busy !== 1'b1) begin
      errors++; $display("FAIL clear_wins got state %0d busy %0b want %0d 1", dbg_state, busy, ST_CLEAR);
    end
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      tick();
      if (plot === 1'b1 && x === 9'd10 && y === 8'd5) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach got no pixel 10,5 want pixel 10,5"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (plot !== 1'b0 || dbg_state !== ST_IDLE || x !== '0 || y !== '0 || overrun !== 1'b0) begin
      errors++; $display("FAIL abort_reset got plot %0b state %0d xy %0d,%0d ovr %0b want 0 0 0,0 0", plot, dbg_state, x, y, overrun);
    end
    plots = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (plot !== 1'b0) plots++;
    end
    checks++; if (plots != 0) begin errors++; $display("FAIL abort_quiet got %0d plots want 0", plots); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (plot !== 1'b1 || x !== '0 || y !== '0) begin
      errors++; $display("FAIL restart_origin got %0b %0d,%0d want 1 0,0", plot, x, y);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    clear_req  = 1'b0;
    frame_tick = 1'b0;
    ch_req     = '0;
    ch_x       = '0;
    ch_y       = '0;
    ch_colour  = '0;
    ch_plot    = '0;
    ch_done    = '0;
    test_reset();
    test_clear();
    test_scan_serve();
    test_empty_frame();
    test_clear_priority_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of sprite channels (1..16).
REQ-002 Parameters X_W/Y_W/COL_W, defaults 9/8/3, coordinate and colour widths.
REQ-003 Parameters SCREEN_W/SCREEN_H, defaults 320/240, clear-sweep extent.
REQ-004 Parameter CLEAR_COLOUR, default 0, colour written during clear.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high.
REQ-007 Port start, input, 1, level; begins initial clear from IDLE.
REQ-008 Port clear_req, input, 1, pulse; requests a re-clear between frames.
REQ-009 Port frame_tick, input, 1, one-cycle frame strobe (1/60 s).
REQ-010 Port ch_req, input, NUM_CH, per-channel "has pixels this frame".
REQ-011 Port ch_x/ch_y/ch_colour, input, NUM_CH*X_W / NUM_CH*Y_W / NUM_CH*COL_W, packed per-channel pixel, channel i at slice i.
REQ-012 Port ch_plot, input, NUM_CH, per-channel pixel valid.
REQ-013 Port ch_done, input, NUM_CH, per-channel last-pixel/finish flag.
REQ-014 Port ch_grant, output, NUM_CH, one-hot grant (or zero).
REQ-015 Port x/y/colour/plot, output, X_W/Y_W/COL_W/1, registered frame-buffer write port.
REQ-016 Port busy, output, 1, high in any state except IDLE and WAIT_FRAME.
REQ-017 Port overrun, output, 1, sticky late-frame flag.

Function
REQ-018 FSM states: IDLE, CLEAR, WAIT_FRAME, SCAN, SERVE.
REQ-019 IDLE -> CLEAR when start=1; otherwise hold.
REQ-020 CLEAR emits x=0..SCREEN_W-1 inner, y=0..SCREEN_H-1 outer, one pixel/cycle, plot=1, colour=CLEAR_COLOUR; exactly SCREEN_W*SCREEN_H plotted cycles.
REQ-021 After pixel (SCREEN_W-1, SCREEN_H-1) -> WAIT_FRAME; counters return to 0.
REQ-022 WAIT_FRAME: clear_req -> CLEAR; else frame_tick -> SCAN with channel index 0; clear_req wins if simultaneous.
REQ-023 SCAN at index i: ch_req[i]=1 -> SERVE with ch_grant = 1<<i; else advance index, 1 cycle per skipped channel.
REQ-024 SERVE: outputs register granted channel's x/y/colour; plot = ch_plot[i]; latency 1 cycle from input to output.
REQ-025 SERVE: ch_done[i]=1 -> grant drops next cycle, index+1 -> SCAN; a pixel with ch_plot and ch_done in the same cycle is written.
REQ-026 Index NUM_CH-1 completed or skipped -> WAIT_FRAME.
REQ-027 Ungranted channels' ch_plot/ch_done ignored; never more than one grant bit high.
REQ-028 frame_tick in CLEAR, SCAN or SERVE: ignored, overrun set to 1; cleared only by reset.
REQ-029 clear_req outside WAIT_FRAME ignored.
REQ-030 plot=0 in IDLE, WAIT_FRAME, SCAN; x/y/colour hold last value when plot=0.

Reset
REQ-031 reset=1 on any edge: state IDLE, x=0, y=0, colour=0, plot=0, ch_grant=0, busy=0, overrun=0, sweep counters 0, channel index 0.
REQ-032 Reset mid-CLEAR or mid-SERVE aborts immediately; no further plot until next start.

Structure
REQ-033 Shared package draw_pkg holds SCREEN_W, SCREEN_H, X_W, Y_W, COL_W defaults and the state encoding.
REQ-034 Channel index width = clog2(NUM_CH), minimum 1.
REQ-035 Sub-module screen_sweep: x/y raster counter with enable and last-pixel flag, used by CLEAR.

Verification
REQ-036 start=1 after reset -> 76800 plot cycles, first (0,0), last (319,239), colour 0, then busy=0.
REQ-037 frame_tick, ch_req=4'b1010 -> grant 4'b0010 then 4'b1000; channels 0,2 skipped in 1 cycle each.
REQ-038 Granted channel 1 drives (5,7,colour 3) plot=1 -> next cycle x=5,y=7,colour=3,plot=1; ch_done with plot -> pixel written, grant drops.
REQ-039 frame_tick during SERVE -> overrun=1, sequence unaffected; overrun remains 1 until reset.
REQ-040 reset=1 mid-CLEAR at pixel (100,50) -> next cycle plot=0, IDLE; clear_req+frame_tick together in WAIT_FRAME -> CLEAR.
